tnoc_flit_serializer: RTL and testbench
=======================================

TNOC_FLIT_SERIALIZER -- requirements
Module: tnoc_flit_serializer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- ID_X_WIDTH, 2, location X field width
- ID_Y_WIDTH, 2, location Y field width
- VCS, 2, virtual channel count; VC_WIDTH = max(1, clog2(VCS))
- TAG_WIDTH, 4, tag width
- LENGTH_WIDTH, 4, payload flit count width
- ADDRESS_WIDTH, 32, request address width
- DATA_WIDTH, 64, payload data width (power of two, 16..256)
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line; the clock and reset are one clock with a synchronous, active-high reset:
- i_clk, in, 1, clock
- i_rst, in, 1, synchronous active-high reset
- i_header_valid, in, 1, header offered
- o_header_ready, out, 1, header accepted
- i_header, in, HEADER_WIDTH, packed header (type, dest, src, vc, tag, length, routing, invalid_dest, address or status/lower_address/last_response)
- i_payload_valid, in, 1, payload beat offered
- o_payload_ready, out, 1, payload beat accepted
- i_payload, in, DATA_WIDTH+DATA_WIDTH/8, data and byte enable
- i_payload_last, in, 1, final beat marker from source
- o_flit_valid, out, 1, flit offered
- i_flit_ready, in, 1, flit accepted
- o_flit, out, FLIT_WIDTH, {flit_type, head, tail, data}
- o_flit_vc, out, VC_WIDTH, VC of the current flit
- o_error, out, 1, one-cycle length-mismatch pulse

Function
REQ-003 A transfer on any channel SHALL occur only when valid and ready are both 1 on a rising i_clk edge; once raised, o_flit_valid SHALL stay 1 and o_flit/o_flit_vc SHALL stay stable until the transfer completes.
REQ-004 FLIT_DATA_WIDTH SHALL equal the maximum of the request header width, the response header width and the payload width; narrower contents SHALL be zero-extended in the LSBs-aligned position.
REQ-005 A packet carries payload iff packet_type[6]=1 (posted write, non-posted write, response with data); read and response packets SHALL produce exactly one flit, with head=1, tail=1 and flit_type=HEADER.
REQ-006 Payload-carrying packets SHALL produce one header flit (head=1, tail=0), then N payload flits (flit_type=PAYLOAD, head=0), with tail=1 on the last; N=length, and length=0 SHALL encode 2^LENGTH_WIDTH.
REQ-007 The FSM SHALL have three states. IDLE: o_header_ready=1 when the output register is empty or is being drained this cycle; on a header accept, go to PAYLOAD when packet_type[6]=1, else stay in IDLE. PAYLOAD: o_payload_ready follows the same output-slot rule. DRAIN: o_payload_ready=1, beats are discarded, and the FSM returns to IDLE on an accepted beat with i_payload_last=1.
REQ-008 Latency SHALL be one cycle from input accept to o_flit_valid; sustained throughput SHALL be one flit per cycle while i_flit_ready=1, including a header accepted in the same cycle as the previous tail leaves.
REQ-009 o_flit_vc SHALL be latched from the header vc field and held for every flit of that packet.
REQ-010 Early last (i_payload_last=1 before beat N): the flit SHALL carry tail=1, o_error SHALL pulse for one cycle, and the FSM SHALL go to IDLE.
REQ-011 Late last (beat N with i_payload_last=0): the flit SHALL carry tail=1, o_error SHALL pulse, and the FSM SHALL go to DRAIN.
REQ-012 The beat counter SHALL be LENGTH_WIDTH+1 bits wide and SHALL NOT wrap within a packet.
REQ-013 Header and payload ready SHALL never both be 1 in the same cycle.

Reset
REQ-014 While i_rst=1, the FSM SHALL be in IDLE, the counter SHALL be 0, and o_flit_valid, o_flit, o_flit_vc, o_error, o_header_ready and o_payload_ready SHALL all be 0.
REQ-015 A reset in mid-packet SHALL discard the partial packet and no tail flit SHALL be emitted afterwards; o_header_ready SHALL assert in the first cycle after i_rst falls.

Structure
REQ-016 The packet_type enum, the location_id/vc/tag/length structs, the header structs, the flit struct, the width localparams and the has_payload function SHALL live in the shared package tnoc_flit_pkg, parametrised through the package macros.
REQ-017 The output holding register SHALL be the sub-module tnoc_flit_slice, with a valid/ready pipeline of one entry.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- READ, vc=1, tag=3, i_flit_ready=1 -> one flit, head=1, tail=1, HEADER, o_flit_vc=1, one cycle after accept.
- POSTED_WRITE length=4, 4 beats with last on beat 4, i_flit_ready=1 -> 5 flits on consecutive cycles, tail only on flit 5, o_error=0.
- NON_POSTED_WRITE length=0, LENGTH_WIDTH=4 -> 1 header + 16 payload flits, tail on flit 17.
- RESPONSE_WITH_DATA length=3, last on beat 2 -> tail on beat 2, o_error pulses once, next header accepted.
- POSTED_WRITE length=2, last on beat 4 -> tail on beat 2, o_error pulse, beats 3-4 dropped, no flits emitted for them.
- i_flit_ready toggled randomly 50% and i_rst asserted mid-payload -> flits stable while stalled, outputs 0 during reset, clean READ accepted afterwards.

Source files
------------

// File: rtl/tnoc_flit_pkg.sv
// Shared types, width helpers and packet classification for the flit serializer.
// Header layout, MSB first: {type, dest{y,x}, src{y,x}, vc, tag, length, routing, invalid_dest, tail}.
package tnoc_flit_pkg;

  typedef enum logic [7:0] {
    TNOC_INVALID            = 8'h00,
    TNOC_READ               = 8'h10,
    TNOC_RESPONSE           = 8'h20,
    TNOC_POSTED_WRITE       = 8'h40,
    TNOC_NON_POSTED_WRITE   = 8'h41,
    TNOC_RESPONSE_WITH_DATA = 8'h60
  } tnoc_packet_type;

  typedef enum logic {
    TNOC_HEADER_FLIT  = 1'b0,
    TNOC_PAYLOAD_FLIT = 1'b1
  } tnoc_flit_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN
  } tnoc_serializer_state;

  localparam int PACKET_TYPE_WIDTH   = 8;
  localparam int ROUTING_WIDTH       = 1;
  localparam int INVALID_DEST_WIDTH  = 1;
  localparam int STATUS_WIDTH        = 2;
  localparam int LOWER_ADDRESS_WIDTH = 7;
  localparam int LAST_RESPONSE_WIDTH = 1;
  // Response tail {status, lower_address, last_response} sits LSB-aligned in the tail field
  localparam int RESPONSE_TAIL_WIDTH = STATUS_WIDTH + LOWER_ADDRESS_WIDTH + LAST_RESPONSE_WIDTH;

  function automatic int tnoc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int common_header_width(input int x_width, input int y_width,
                                             input int vc_width, input int tag_width,
                                             input int length_width);
    return PACKET_TYPE_WIDTH + 2 * (x_width + y_width) + vc_width + tag_width
           + length_width + ROUTING_WIDTH + INVALID_DEST_WIDTH;
  endfunction

  function automatic logic has_payload(input logic [PACKET_TYPE_WIDTH-1:0] packet_type);
    return packet_type[6];
  endfunction

endpackage

// File: rtl/tnoc_flit_slice.sv
// One-entry valid/ready holding register; data only moves when the slot is empty or draining.
module tnoc_flit_slice #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/tnoc_flit_serializer.sv
// Turns a header plus payload beats into head/payload/tail flits, policing the beat count
// against the header length and discarding surplus beats.
module tnoc_flit_serializer
  import tnoc_flit_pkg::*;
#(
  parameter int ID_X_WIDTH    = 2,
  parameter int ID_Y_WIDTH    = 2,
  parameter int VCS           = 2,
  parameter int TAG_WIDTH     = 4,
  parameter int LENGTH_WIDTH  = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 64,
  localparam int VC_WIDTH        = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int COMMON_WIDTH    = common_header_width(ID_X_WIDTH, ID_Y_WIDTH, VC_WIDTH,
                                                       TAG_WIDTH, LENGTH_WIDTH),
  localparam int TAIL_WIDTH      = tnoc_max(ADDRESS_WIDTH, RESPONSE_TAIL_WIDTH),
  localparam int HEADER_WIDTH    = COMMON_WIDTH + TAIL_WIDTH,
  localparam int PAYLOAD_WIDTH   = DATA_WIDTH + DATA_WIDTH / 8,
  localparam int FLIT_DATA_WIDTH = tnoc_max(HEADER_WIDTH, PAYLOAD_WIDTH),
  localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_header_valid,
  output logic                     o_header_ready,
  input  logic [HEADER_WIDTH-1:0]  i_header,
  input  logic                     i_payload_valid,
  output logic                     o_payload_ready,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  input  logic                     i_payload_last,
  output logic                     o_flit_valid,
  input  logic                     i_flit_ready,
  output logic [FLIT_WIDTH-1:0]    o_flit,
  output logic [VC_WIDTH-1:0]      o_flit_vc,
  output logic                     o_error
);

  localparam int LENGTH_LSB = TAIL_WIDTH + ROUTING_WIDTH + INVALID_DEST_WIDTH;
  localparam int VC_LSB     = LENGTH_LSB + LENGTH_WIDTH + TAG_WIDTH;

  tnoc_serializer_state r_state, w_next_state;
  logic [LENGTH_WIDTH:0]  r_count, w_count_next, r_length, w_length_next, w_beat;
  logic [VC_WIDTH-1:0]    r_vc, w_vc;
  logic                   r_error, w_error;

  logic [PACKET_TYPE_WIDTH-1:0] w_hdr_type;
  logic [LENGTH_WIDTH-1:0]      w_hdr_length;
  logic [VC_WIDTH-1:0]          w_hdr_vc;
  logic                         w_slot_ready, w_slice_valid, w_last_beat;
  logic                         w_header_ready, w_payload_ready;
  tnoc_flit_type                w_flit_type;
  logic                         w_head, w_tail;
  logic [FLIT_DATA_WIDTH-1:0]   w_data;

  assign w_hdr_type   = i_header[HEADER_WIDTH-1 -: PACKET_TYPE_WIDTH];
  assign w_hdr_length = i_header[LENGTH_LSB +: LENGTH_WIDTH];
  assign w_hdr_vc     = i_header[VC_LSB +: VC_WIDTH];

  always_comb begin
    w_next_state    = r_state;
    w_count_next    = r_count;
    w_length_next   = r_length;
    w_vc            = r_vc;
    w_error         = 1'b0;
    w_slice_valid   = 1'b0;
    w_flit_type     = TNOC_HEADER_FLIT;
    w_head          = 1'b0;
    w_tail          = 1'b0;
    w_data          = '0;
    w_header_ready  = 1'b0;
    w_payload_ready = 1'b0;
    w_beat          = r_count + 1'b1;
    w_last_beat     = (w_beat == r_length);
    case (r_state)
      ST_IDLE: begin
        w_header_ready = w_slot_ready;
        if (i_header_valid && w_slot_ready) begin
          w_slice_valid = 1'b1;
          w_head        = 1'b1;
          w_tail        = !has_payload(w_hdr_type);
          w_data        = FLIT_DATA_WIDTH'(i_header);
          w_vc          = w_hdr_vc;
          w_count_next  = '0;
          // length 0 means 2^LENGTH_WIDTH: the extra MSB becomes 1
          w_length_next = {(w_hdr_length == '0), w_hdr_length};
          if (has_payload(w_hdr_type)) begin
            w_next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        w_payload_ready = w_slot_ready;
        if (i_payload_valid && w_slot_ready) begin
          w_slice_valid = 1'b1;
          w_flit_type   = TNOC_PAYLOAD_FLIT;
          w_tail        = w_last_beat || i_payload_last;
          w_data        = FLIT_DATA_WIDTH'(i_payload);
          w_count_next  = w_beat;
          w_error       = (w_last_beat != i_payload_last);
          if (i_payload_last) begin
            w_next_state = ST_IDLE;
          end else if (w_last_beat) begin
            w_next_state = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_payload_ready = 1'b1;
        if (i_payload_valid && i_payload_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_length <= '0;
      r_vc     <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_count_next;
      r_length <= w_length_next;
      r_vc     <= w_vc;
      r_error  <= w_error;
    end
  end

  assign o_header_ready  = w_header_ready && !i_rst;
  assign o_payload_ready = w_payload_ready && !i_rst;
  assign o_error         = r_error;

  tnoc_flit_slice #(
    .WIDTH (VC_WIDTH + FLIT_WIDTH)
  ) u_slice (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_slice_valid),
    .o_ready (w_slot_ready),
    .i_data  ({w_vc, w_flit_type, w_head, w_tail, w_data}),
    .o_valid (o_flit_valid),
    .i_ready (i_flit_ready),
    .o_data  ({o_flit_vc, o_flit})
  );

endmodule

// File: tb/tb_tnoc_flit_serializer.sv
// Scoreboard bench: packets are expanded into expected flits when issued; a monitor checks
// every flit that leaves the serializer, plus stall stability and error pulses.
module tb_tnoc_flit_serializer;
  import tnoc_flit_pkg::*;

  localparam int HW  = 59;
  localparam int PW  = 72;
  localparam int FDW = 72;
  localparam int FW  = FDW + 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_header_valid = 1'b0;
  logic          o_header_ready;
  logic [HW-1:0] i_header = '0;
  logic          i_payload_valid = 1'b0;
  logic          o_payload_ready;
  logic [PW-1:0] i_payload = '0;
  logic          i_payload_last = 1'b0;
  logic          o_flit_valid;
  logic          i_flit_ready = 1'b1;
  logic [FW-1:0] o_flit;
  logic          o_flit_vc;
  logic          o_error;

  tnoc_flit_serializer #(
    .ID_X_WIDTH    (2),
    .ID_Y_WIDTH    (2),
    .VCS           (2),
    .TAG_WIDTH     (4),
    .LENGTH_WIDTH  (4),
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (64)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_header_valid  (i_header_valid),
    .o_header_ready  (o_header_ready),
    .i_header        (i_header),
    .i_payload_valid (i_payload_valid),
    .o_payload_ready (o_payload_ready),
    .i_payload       (i_payload),
    .i_payload_last  (i_payload_last),
    .o_flit_valid    (o_flit_valid),
    .i_flit_ready    (i_flit_ready),
    .o_flit          (o_flit),
    .o_flit_vc       (o_flit_vc),
    .o_error         (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [FW-1:0] flit;
    logic          vc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails = 0;
  int          exp_errors = 0;
  int          seen_errors = 0;
  int          cycle = 0;
  int          last_xfer = 0;
  bit          rand_ready = 1'b0;
  bit          b2b = 1'b0;
  bit          stall_pending = 1'b0;
  logic [FW:0] stall_val;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    i_flit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge i_clk) begin
    exp_t e;
    cycle++;
    if (i_rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid_held", o_flit_valid, 1);
        check("stall_flit_held", {o_flit_vc, o_flit}, stall_val);
      end
      stall_pending = o_flit_valid && !i_flit_ready;
      stall_val     = {o_flit_vc, o_flit};
      check("ready_exclusive", o_header_ready & o_payload_ready, 0);
      if (o_error) seen_errors++;
      if (o_flit_valid && i_flit_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_flit: got %h expected none (cycle %0d)", o_flit, cycle);
        end else begin
          e = exp_q.pop_front();
          check("flit", o_flit, e.flit);
          check("flit_vc", o_flit_vc, e.vc);
          if (b2b && !o_flit[FW-2]) check("back_to_back", cycle, last_xfer + 1);
        end
        last_xfer = cycle;
      end
    end
  end

  // which: 0 = header channel, 1 = payload channel; returns just after the accepting edge
  task automatic handshake(input int which);
    logic rdy;
    int   guard;
    guard = 0;
    do begin
      @(negedge i_clk);
      rdy = (which == 0) ? o_header_ready : o_payload_ready;
      @(posedge i_clk);
      guard++;
    end while (!rdy && guard < 400);
    if (!rdy) begin
      n_checks++;
      n_fails++;
      $display("FAIL handshake_timeout: got no ready expected ready on channel %0d", which);
    end
    #1;
  endtask

  task automatic send_packet(input logic [7:0] t, input logic vc, input logic [3:0] tag,
                             input logic [3:0] len, input int nbeats, input int abort_after);
    logic [HW-1:0] hdr;
    logic [PW-1:0] beats[$];
    exp_t          e;
    int            n, k;
    bit            pay;
    n   = (len == 0) ? 16 : int'(len);
    pay = t[6];
    k   = (nbeats < n) ? nbeats : n;
    hdr = {t, 4'($urandom), 4'($urandom), vc, tag, len, 1'($urandom), 1'($urandom),
           32'($urandom)};
    e.flit = {1'b0, 1'b1, !pay, FDW'(hdr)};
    e.vc   = vc;
    exp_q.push_back(e);
    if (pay) begin
      for (int i = 1; i <= nbeats; i++) begin
        beats.push_back({$urandom, $urandom, 8'($urandom)});
        if (i <= k) begin
          e.flit = {1'b1, 1'b0, (i == k), beats[i-1]};
          exp_q.push_back(e);
        end
      end
      if (abort_after == 0 && nbeats != n) exp_errors++;
    end
    i_header       = hdr;
    i_header_valid = 1'b1;
    handshake(0);
    check("accept_latency", o_flit_valid, 1);
    i_header_valid = 1'b0;
    if (pay) begin
      for (int i = 1; i <= nbeats; i++) begin
        if (abort_after > 0 && i > abort_after) break;
        i_payload       = beats[i-1];
        i_payload_last  = (i == nbeats);
        i_payload_valid = 1'b1;
        handshake(1);
        if (i == k && abort_after == 0) check("error_pulse", o_error, (nbeats != n));
      end
      i_payload_valid = 1'b0;
      i_payload_last  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge i_clk);
    check("rst_flit_valid", o_flit_valid, 0);
    check("rst_flit", o_flit, 0);
    check("rst_flit_vc", o_flit_vc, 0);
    check("rst_error", o_error, 0);
    check("rst_header_ready", o_header_ready, 0);
    check("rst_payload_ready", o_payload_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] types[5];
    int         n, m;
    logic [3:0] len;
    types = '{TNOC_READ, TNOC_RESPONSE, TNOC_POSTED_WRITE, TNOC_NON_POSTED_WRITE,
              TNOC_RESPONSE_WITH_DATA};

    repeat (3) @(posedge i_clk);
    check_reset_outputs();
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    b2b = 1'b1;
    send_packet(TNOC_READ, 1'b1, 4'd3, 4'd2, 0, 0);
    send_packet(TNOC_POSTED_WRITE, 1'b0, 4'd1, 4'd4, 4, 0);
    send_packet(TNOC_NON_POSTED_WRITE, 1'b1, 4'd7, 4'd0, 16, 0);
    send_packet(TNOC_RESPONSE_WITH_DATA, 1'b0, 4'd2, 4'd3, 2, 0);
    send_packet(TNOC_RESPONSE, 1'b1, 4'd4, 4'd0, 0, 0);
    send_packet(TNOC_POSTED_WRITE, 1'b1, 4'd9, 4'd2, 4, 0);
    send_packet(TNOC_READ, 1'b0, 4'd5, 4'd1, 0, 0);
    b2b = 1'b0;

    rand_ready = 1'b1;
    send_packet(TNOC_POSTED_WRITE, 1'b1, 4'd5, 4'd8, 8, 3);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 exp_q.delete();
    check_reset_outputs();
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("header_ready_after_reset", o_header_ready, 1);
    @(posedge i_clk);
    #1;
    send_packet(TNOC_READ, 1'b1, 4'd6, 4'd0, 0, 0);

    for (int p = 0; p < 40; p++) begin
      len = 4'($urandom);
      n   = (len == 0) ? 16 : int'(len);
      case ($urandom_range(0, 3))
        0:       m = (n > 1) ? n - 1 : n;
        1:       m = n + 1 + int'($urandom_range(0, 1));
        default: m = n;
      endcase
      send_packet(types[$urandom_range(0, 4)], 1'($urandom), 4'($urandom), len, m, 0);
    end

    rand_ready = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge i_clk);
    repeat (5) @(posedge i_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("error_pulse_count", seen_errors, exp_errors);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
